// File: rtl/spy_initiator.sv
// Spy bus initiator: accepts one examine/deposit command at a time from the
// host agent and runs it on the spy bus with programmable setup/strobe/hold
// timing. It returns exactly one response per completed command.
module spy_initiator #(
    parameter int unsigned SETUP  = 1,
    parameter int unsigned STROBE = 2,
    parameter int unsigned HOLD   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic [4:0]  eadr,
    output logic        dbread,
    output logic        dbwrite,
    output logic [15:0] spy_out,
    input  logic [15:0] spy_in
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    // Counter reload values: each phase lasts (reload + 1) cycles.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic       is_write;

    // Sequencer: every output is a flop; phases advance when cnt reaches zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            is_write  <= 1'b0;
            cmd_ready <= 1'b1;
            eadr      <= 5'd0;
            spy_out   <= 16'd0;
            dbread    <= 1'b0;
            dbwrite   <= 1'b0;
            rsp_rdata <= 16'd0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        is_write  <= cmd_write;
                        eadr      <= cmd_addr;
                        // Examines leave the last deposit data on the bus.
                        if (cmd_write) begin
                            spy_out <= cmd_wdata;
                        end
                        cnt       <= SETUP_LD;
                        cmd_ready <= 1'b0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == 4'd0) begin
                        dbwrite <= is_write;
                        dbread  <= !is_write;
                        cnt     <= STROBE_LD;
                        state   <= S_STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_STROBE: begin
                    if (cnt == 4'd0) begin
                        dbwrite <= 1'b0;
                        dbread  <= 1'b0;
                        // Read data is captured on the edge that ends the strobe.
                        rsp_rdata <= is_write ? 16'd0 : spy_in;
                        cnt       <= HOLD_LD;
                        state     <= S_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    dbread    <= 1'b0;
                    dbwrite   <= 1'b0;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
